// File: rtl/r8b_pkg.sv
// Shared definitions for the r8b GPR sequencer: opcodes, FSM states and
// the one-hot index decode used for every register enable.
package r8b_pkg;

  localparam int IDX_W_DEF = 2;

  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_IMM   = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  // Indices of 32 or more shift out to an all-zero vector.
  function automatic logic [31:0] idx_onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/r8b_rr_arb2.sv
// Two-requester round-robin arbiter. The last-grant pointer moves only when
// the owner of the grant actually accepts (advance high with a live grant).
module r8b_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q = 1 means requester 1 won last, so requester 0 is favoured.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/r8b_gpr_seq.sv
// Sequencer for the r8b GPR bank: arbitrates two command sources and turns
// each accepted register transfer into one-hot bus enables, decoded from flops only.
module r8b_gpr_seq
  import r8b_pkg::*;
#(
  parameter int NREG    = 4,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0][IDX_W-1:0] req_dst,
  input  logic [1:0][IDX_W-1:0] req_srca,
  input  logic [1:0][IDX_W-1:0] req_srcb,
  output logic [NREG-1:0]       reg_load,
  output logic [NREG-1:0]       reg_write,
  output logic [NREG-1:0]       assert_lhs,
  output logic [NREG-1:0]       assert_rhs,
  output logic                  alu_drive,
  output logic                  imm_drive,
  output logic                  store_strobe,
  output logic                  done,
  output logic                  done_id,
  output logic                  err,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  dst_q, srca_q, srcb_q;
  logic              owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        grant;
  logic              idle, accept, bad;
  logic              a_ok, b_ok, d_ok;
  logic [NREG-1:0]   oh_a, oh_b, oh_d;

  // Handshake: req_ready[i] is high only in IDLE and only for the arbitration
  // winner; a command transfers at the posedge where req_valid[i] && req_ready[i].
  assign idle      = (state_q == ST_IDLE);
  assign req_ready = grant;
  assign accept    = (grant != 2'b00);
  assign dbg_state = state_q;

  r8b_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid & {2{idle}}),
    .advance (idle),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOV;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (idle && accept) begin
        op_q    <= req_op[grant[1]];
        dst_q   <= req_dst[grant[1]];
        srca_q  <= req_srca[grant[1]];
        srcb_q  <= req_srcb[grant[1]];
        owner_q <= grant[1];
        cnt_q   <= '0;
      end else if (state_q == ST_OPER) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign a_ok = (32'(srca_q) < 32'(NREG));
  assign b_ok = (32'(srcb_q) < 32'(NREG));
  assign d_ok = (32'(dst_q)  < 32'(NREG));
  assign oh_a = NREG'(idx_onehot(32'(srca_q)));
  assign oh_b = NREG'(idx_onehot(32'(srcb_q)));
  assign oh_d = NREG'(idx_onehot(32'(dst_q)));

  // Only the indices an opcode actually uses can make it invalid.
  always_comb begin
    bad = 1'b0;
    case (op_q)
      OP_MOV:   bad = !(a_ok && d_ok);
      OP_ALU:   bad = !(a_ok && b_ok && d_ok);
      OP_IMM:   bad = !d_ok;
      OP_STORE: bad = !a_ok;
      default:  bad = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    reg_load     = '0;
    reg_write    = '0;
    assert_lhs   = '0;
    assert_rhs   = '0;
    alu_drive    = 1'b0;
    imm_drive    = 1'b0;
    store_strobe = 1'b0;
    done         = 1'b0;
    done_id      = 1'b0;
    err          = 1'b0;
    busy         = !idle;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (req_op[grant[1]] == OP_ALU) ? ST_OPER : ST_EXEC;
      end
      ST_OPER: begin
        if (!bad) begin
          assert_lhs = oh_a;
          assert_rhs = oh_b;
        end
        if (cnt_q == CNT_W'(ALU_LAT - 1)) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        done    = 1'b1;
        done_id = owner_q;
        err     = bad;
        if (!bad) begin
          case (op_q)
            OP_MOV: begin
              // A self-move would put one register on the bus and load it back.
              if (srca_q != dst_q) begin
                reg_write = oh_a;
                reg_load  = oh_d;
              end
            end
            OP_ALU: begin
              assert_lhs = oh_a;
              assert_rhs = oh_b;
              alu_drive  = 1'b1;
              reg_load   = oh_d;
            end
            OP_IMM: begin
              imm_drive = 1'b1;
              reg_load  = oh_d;
            end
            default: begin
              reg_write    = oh_a;
              store_strobe = 1'b1;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/r8b_gpr_seq.md
Name: r8b_gpr_seq

Overview:
Sequencer and arbiter for the r8b general-purpose register bank. Accepts register-transfer commands from two requesters (req0 = decode stage, req1 = debug/monitor port) over valid/ready handshakes, with round-robin arbitration between them. Generates per-register one-hot load/write/LHS/RHS enables plus ALU and immediate bus-drive enables. Guarantees at most one driver per bus in every cycle.

Parameters:
NREG, 4, number of GPRs sequenced (max 2**IDX_W)
IDX_W, 2, width of register index fields
ALU_LAT, 1, cycles operands are held on LHS/RHS before the ALU result is valid on the main bus (>=1)

Ports:
clk  in  1  system clock; state updates on posedge, GPRs load on negedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  command valid, bit i = requester i
req_ready  out  2  command accepted, bit i = requester i
req_op  in  2x2  opcode per requester: 00 MOV, 01 ALU, 10 IMM, 11 STORE
req_dst  in  2xIDX_W  destination index per requester
req_srca  in  2xIDX_W  source / LHS index per requester
req_srcb  in  2xIDX_W  RHS index per requester
reg_load  out  NREG  one-hot GPR load enables
reg_write  out  NREG  one-hot main-bus drive enables
assert_lhs  out  NREG  one-hot LHS drive enables
assert_rhs  out  NREG  one-hot RHS drive enables
alu_drive  out  1  ALU result drives main bus
imm_drive  out  1  immediate latch drives main bus
store_strobe  out  1  main-bus value valid for external capture
done  out  1  one-cycle pulse in the final execution cycle
done_id  out  1  requester that owns the completing command
err  out  1  one-cycle pulse alongside done when the command had an out-of-range index
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low. While reset is low or on release:
  - all enables, done, err and busy are 0;
  - state is IDLE;
  - round-robin pointer favours req0.
- States: IDLE, OPER, EXEC.
- IDLE, arbitration:
  - req_ready is asserted combinationally to the single arbitration winner only while in IDLE.
  - With one valid requester, that requester wins.
  - With both valid, the requester not granted last wins.
  - The pointer updates only on acceptance.
  - At posedge with ready&&valid, the command and owner id are latched.
  - Next state is OPER for ALU, EXEC otherwise.
- OPER (ALU only): lasts ALU_LAT cycles. assert_lhs[srca] and assert_rhs[srcb] are 1; all else 0. srca==srcb is legal (separate buses).
- EXEC (always exactly 1 cycle), then IDLE. done=1 and done_id=owner. Enables per opcode:
  - MOV: reg_write[srca] and reg_load[dst]. srca==dst suppresses all enables but still signals done.
  - ALU: assert_lhs[srca], assert_rhs[srcb] held; alu_drive and reg_load[dst].
  - IMM: imm_drive and reg_load[dst].
  - STORE: reg_write[srca] and store_strobe.
- Timing:
  - Enables are decoded only from flops (state and latched command), so they are stable before the negedge GPR load.
  - No enable depends combinationally on req_* inputs.
- Latency from acceptance edge to done:
  - 1 cycle for MOV, IMM and STORE;
  - ALU_LAT+1 cycles for ALU.
  - Minimum spacing between acceptances is 2 cycles, because IDLE is revisited after every command.
- Out-of-range index (any used index >= NREG): the command is still executed for timing. All reg_*/assert_* enables are suppressed, as are alu_drive/imm_drive/store_strobe. err=1 with done.
- Invariants, every cycle:
  - popcount(reg_write)+alu_drive+imm_drive <= 1;
  - popcount(reg_load) <= 1;
  - popcount(assert_lhs) <= 1;
  - popcount(assert_rhs) <= 1.
- Inputs changing while not ready are ignored. A requester may drop valid before acceptance with no effect.
- Reset asserted mid-command: enables drop immediately (asynchronously) and the command is discarded. No partial load occurs, provided reset precedes the negedge.

Decomposition:
- Shared package r8b_pkg holds:
  - opcode constants OP_MOV/OP_ALU/OP_IMM/OP_STORE;
  - the state enum;
  - the default index width.
- Natural sub-module: r8b_rr_arb2, a two-requester round-robin arbiter with a registered last-grant pointer and an advance-on-accept input.
- One-hot index decode is a function in r8b_pkg.

Test Plan:
1. Reset mid-ALU: rst_n low during OPER -> all enables 0 immediately; after release busy=0 and no reg_load has pulsed.
2. MOV: req0 MOV srca=1,dst=3 -> next cycle reg_write=0010, reg_load=1000, done=1, done_id=0, then IDLE.
3. ALU with ALU_LAT=2: req1 ALU srca=2,srcb=2,dst=0 -> assert_lhs=assert_rhs=0100 for 3 cycles. In the 3rd cycle alu_drive=1, reg_load=0001, done=1, done_id=1.
4. Both requesters held valid with IMM commands -> acceptances alternate 0,1,0,1 every 2 cycles; each done cycle shows imm_drive=1.
5. MOV srca=dst=2 -> done=1 with all enables 0. With NREG=3, MOV dst=3 -> done=1, err=1, reg_load=000.
6. Random command stream, 10k cycles -> bus-exclusivity invariants never violated; done count equals acceptance count per requester.
